// File: rtl/mul_pipe_arb.sv
// Two-requester round-robin front end for a shared fixed-latency multiplier, with a credit-guarded result FIFO.
// Define MUL_PIPE_ARB_FIXED_PRIO_EN to make requester 0 always win instead of round-robin.
module mul_pipe_arb #(
  parameter int EXPO_W     = 8,
  parameter int MANT_W     = 23,
  parameter int MUL_LAT    = 3,
  parameter int FIFO_DEPTH = 4,
  localparam int W         = 1 + EXPO_W + MANT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_vld,
  output logic [1:0]   req_rdy,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         mul_vld,
  output logic [W-1:0] mul_a,
  output logic [W-1:0] mul_b,
  input  logic [W-1:0] mul_res,
  output logic         rsp_vld,
  input  logic         rsp_rdy,
  output logic [W-1:0] rsp_res,
  output logic         rsp_id,
  output logic         busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Handshakes: a transfer happens on a rising clk edge where vld & rdy are both high;
  // req_rdy is offered only to the arbitration winner, rsp_res/rsp_id hold while rsp_vld & ~rsp_rdy.
  logic [CW-1:0] credit_q;
  logic          gnt_id;
  logic          req_hs;
  logic          rsp_hs;
  logic          iss_id_q;
  logic [MUL_LAT-1:0] pipe_vld_q;
  logic [MUL_LAT-1:0] pipe_id_q;
  logic          cap_vld;
  logic          cap_id;

  logic [W-1:0]  fifo_res [FIFO_DEPTH];
  logic          fifo_id  [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

`ifdef MUL_PIPE_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_id = ~req_vld[0] & req_vld[1];
  end
`else
  logic prio_q;

  always_comb begin
    case (req_vld)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      default: gnt_id = prio_q;
    endcase
  end

  // After serving requester i, the other one gets priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else if (req_hs) begin
      prio_q <= ~gnt_id;
    end
  end
`endif

  always_comb begin
    req_rdy[0] = ~rst & (credit_q != '0) & ~gnt_id;
    req_rdy[1] = ~rst & (credit_q != '0) & gnt_id;
    req_hs     = |(req_vld & req_rdy);
    rsp_vld    = (count_q != '0);
    rsp_hs     = rsp_vld & rsp_rdy;
    rsp_res    = rsp_vld ? fifo_res[rd_ptr_q] : '0;
    rsp_id     = rsp_vld ? fifo_id[rd_ptr_q]  : 1'b0;
    busy       = (credit_q != CW'(FIFO_DEPTH));
    cap_vld    = pipe_vld_q[MUL_LAT-1];
    cap_id     = pipe_id_q[MUL_LAT-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_vld  <= 1'b0;
      mul_a    <= '0;
      mul_b    <= '0;
      iss_id_q <= 1'b0;
    end else begin
      mul_vld <= req_hs;
      if (req_hs) begin
        mul_a    <= gnt_id ? req1_a : req0_a;
        mul_b    <= gnt_id ? req1_b : req0_b;
        iss_id_q <= gnt_id;
      end
    end
  end

  // Shadow of the multiplier pipeline: its last stage lines up with mul_res.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld_q <= '0;
      pipe_id_q  <= '0;
    end else begin
      pipe_vld_q[0] <= mul_vld;
      pipe_id_q[0]  <= iss_id_q;
      for (int k = 1; k < MUL_LAT; k++) begin
        pipe_vld_q[k] <= pipe_vld_q[k-1];
        pipe_id_q[k]  <= pipe_id_q[k-1];
      end
    end
  end

  // Credits cover everything between accept and response, so a capture always finds room.
  always_ff @(posedge clk) begin
    if (cap_vld) begin
      fifo_res[wr_ptr_q] <= mul_res;
      fifo_id[wr_ptr_q]  <= cap_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (cap_vld) begin
        wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (rsp_hs) begin
        rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      count_q <= count_q + CW'(cap_vld) - CW'(rsp_hs);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q <= CW'(FIFO_DEPTH);
    end else begin
      case ({req_hs, rsp_hs})
        2'b10:   credit_q <= credit_q - CW'(1);
        2'b01:   credit_q <= credit_q + CW'(1);
        default: credit_q <= credit_q;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_pipe_arb.sv
// Bench for mul_pipe_arb: model multiplier, scoreboard of expected responses, directed and random phases.
module tb_mul_pipe_arb;
  localparam int W     = 32;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_vld;
  logic [1:0]   req_rdy;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         mul_vld;
  logic [W-1:0] mul_a, mul_b, mul_res;
  logic         rsp_vld;
  logic         rsp_rdy;
  logic [W-1:0] rsp_res;
  logic         rsp_id;
  logic         busy;

  always #5 clk = ~clk;

  mul_pipe_arb #(
    .EXPO_W(8), .MANT_W(23), .MUL_LAT(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .mul_vld(mul_vld), .mul_a(mul_a), .mul_b(mul_b), .mul_res(mul_res),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_res(rsp_res), .rsp_id(rsp_id),
    .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cnt  = 0;
  logic [1:0] acc_last = 2'b00;
  logic [W:0] exp_q[$];
  int         gnt_log[$];

  function automatic logic [W-1:0] mul_model(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a == 32'h3FC0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a ^ {b[15:0], b[31:16]};
  endfunction

  task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Shared multiplier model: result appears LAT cycles after the issue cycle.
  logic [W-1:0] mres_sh [LAT];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    mres_sh[0] <= mul_model(mul_a, mul_b);
    for (int k = 1; k < LAT; k++) mres_sh[k] <= mres_sh[k-1];
  end
  assign mul_res = mres_sh[LAT-1];

  // Monitor: inputs are stable at negedge, so handshakes seen here complete at the next posedge.
  always @(negedge clk) begin
    acc_last = req_vld & req_rdy;
    if (!rst) begin
      if (acc_last == 2'b11) check("one_accept", {31'd0, acc_last}, 33'd1);
      if (acc_last[0]) begin
        exp_q.push_back({1'b0, mul_model(req0_a, req0_b)});
        gnt_log.push_back(0);
        acc_cnt++;
      end
      if (acc_last[1]) begin
        exp_q.push_back({1'b1, mul_model(req1_a, req1_b)});
        gnt_log.push_back(1);
        acc_cnt++;
      end
      if (rsp_vld && rsp_rdy) begin
        if (exp_q.size() == 0) check("sb_nonempty", 33'd0, 33'd1);
        else check("rsp", {rsp_id, rsp_res}, exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic [1:0] vld, input logic rr);
    @(posedge clk); #1;
    if (acc_last[0]) begin req0_a = $urandom; req0_b = $urandom; end
    if (acc_last[1]) begin req1_a = $urandom; req1_b = $urandom; end
    req_vld = vld;
    rsp_rdy = rr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_vld = 2'b00;
    exp_q.delete();
    gnt_log.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  int t0;
  int got_vld;
  logic [W-1:0] head;

  initial begin
    rst = 1'b1; req_vld = 2'b00; rsp_rdy = 1'b0;
    req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
    repeat (2) @(posedge clk);
    sample();
    check("rst_req_rdy", {31'd0, req_rdy}, 33'd0);
    check("rst_mul_vld", {32'd0, mul_vld}, 33'd0);
    check("rst_mul_a", {1'b0, mul_a}, 33'd0);
    check("rst_mul_b", {1'b0, mul_b}, 33'd0);
    check("rst_rsp_vld", {32'd0, rsp_vld}, 33'd0);
    check("rst_rsp", {rsp_id, rsp_res}, 33'd0);
    check("rst_busy", {32'd0, busy}, 33'd0);
    check("rst_credit", 33'(dut.credit_q), 33'(DEPTH));
    @(posedge clk); #1;
    rst = 1'b0;

    // Single request 1.5 * 2.0 through the model multiplier.
    step(2'b01, 1'b1);
    req0_a = 32'h3FC0_0000; req0_b = 32'h4000_0000;
    sample();
    check("a_rdy0", {32'd0, req_rdy[0]}, 33'd1);
    t0 = cyc;
    step(2'b00, 1'b1);
    sample();
    check("a_mul_vld", {32'd0, mul_vld}, 33'd1);
    check("a_mul_a", {1'b0, mul_a}, {1'b0, 32'h3FC0_0000});
    check("a_mul_b", {1'b0, mul_b}, {1'b0, 32'h4000_0000});
    got_vld = 0;
    for (int i = 0; i < 20 && got_vld == 0; i++) begin
      if (rsp_vld) got_vld = 1;
      else sample();
    end
    check("a_rsp_seen", 33'(got_vld), 33'd1);
    check("a_latency", 33'(cyc - t0), 33'd5);
    check("a_rsp", {rsp_id, rsp_res}, {1'b0, 32'h4040_0000});
    repeat (4) step(2'b00, 1'b1);
    sample();
    check("a_idle_busy", {32'd0, busy}, 33'd0);

    // Both requesters held: grant order.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step(2'b11, 1'b1);
      sample();
      if (gnt_log.size() >= 6) break;
    end
    step(2'b00, 1'b1);
    check("b_grants", 33'(gnt_log.size()), 33'd6);
    for (int i = 0; i < 6 && i < gnt_log.size(); i++) begin
`ifdef MUL_PIPE_ARB_FIXED_PRIO_EN
      check($sformatf("b_gnt%0d", i), 33'(gnt_log[i]), 33'd0);
`else
      check($sformatf("b_gnt%0d", i), 33'(gnt_log[i]), 33'(i % 2));
`endif
    end
    repeat (12) step(2'b00, 1'b1);

    // Back-pressure: credits run out at FIFO_DEPTH accepts.
    do_reset();
    acc_cnt = 0;
    repeat (12) step(2'b01, 1'b0);
    sample();
    check("c_accepts", 33'(acc_cnt), 33'(DEPTH));
    check("c_rdy_low", {32'd0, req_rdy[0]}, 33'd0);
    check("c_rsp_vld", {32'd0, rsp_vld}, 33'd1);
    head = (exp_q.size() != 0) ? exp_q[0][W-1:0] : '0;
    for (int i = 0; i < 3; i++) begin
      step(2'b01, 1'b0);
      sample();
      check("c_hold", {rsp_id, rsp_res}, {1'b0, head});
    end
    acc_cnt = 0;
    step(2'b01, 1'b1);
    repeat (8) step(2'b01, 1'b0);
    sample();
    check("c_one_more", 33'(acc_cnt), 33'd1);
    repeat (15) step(2'b00, 1'b1);
    sample();
    check("c_drained", 33'(exp_q.size()), 33'd0);
    check("c_busy", {32'd0, busy}, 33'd0);

    // credit=1 with a simultaneous accept and response.
    do_reset();
    repeat (3) step(2'b01, 1'b0);
    repeat (8) step(2'b00, 1'b0);
    sample();
    check("d_credit1", 33'(dut.credit_q), 33'd1);
    step(2'b01, 1'b1);
    sample();
    check("d_both_hs", {31'd0, req_rdy[0], rsp_vld}, 33'd3);
    step(2'b00, 1'b0);
    sample();
    check("d_credit_kept", 33'(dut.credit_q), 33'd1);
    repeat (15) step(2'b00, 1'b1);
    sample();
    check("d_drained", 33'(exp_q.size()), 33'd0);

    // Reset two cycles after an accept discards the in-flight result.
    step(2'b01, 1'b1);
    step(2'b00, 1'b1);
    step(2'b00, 1'b1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(2'b00, 1'b1);
      sample();
      check("e_no_rsp", {32'd0, rsp_vld}, 33'd0);
    end
    check("e_busy", {32'd0, busy}, 33'd0);
    check("e_credit", 33'(dut.credit_q), 33'(DEPTH));

    // Random traffic against the scoreboard.
    for (int i = 0; i < 300; i++) begin
      step(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
    end
    repeat (20) step(2'b00, 1'b1);
    sample();
    check("f_drained", 33'(exp_q.size()), 33'd0);
    check("f_busy", {32'd0, busy}, 33'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_pipe_arb.md
MUL_PIPE_ARB -- requirements
Module: mul_pipe_arb

Interface
REQ-001 SHALL have parameter EXPO_W, default 8, exponent width.
REQ-002 SHALL have parameter MANT_W, default 23, mantissa width; W = 1+EXPO_W+MANT_W.
REQ-003 SHALL have parameter MUL_LAT, default 3, fixed multiplier latency in cycles (>=1).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, result FIFO entries (>=1).
REQ-005 SHALL have port clk  in  1  single clock, all logic on posedge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port req_vld  in  2  per-requester operand valid.
REQ-008 SHALL have port req_rdy  out  2  per-requester accept.
REQ-009 SHALL have port req0_a, req0_b, req1_a, req1_b  in  W each  packed {sign,expo,mant} operands.
REQ-010 SHALL have port mul_vld  out  1  issue strobe to the shared multiplier.
REQ-011 SHALL have port mul_a, mul_b  out  W each  operands to the multiplier.
REQ-012 SHALL have port mul_res  in  W  multiplier result, valid exactly MUL_LAT cycles after mul_vld.
REQ-013 SHALL have port rsp_vld  out  1  result available.
REQ-014 SHALL have port rsp_rdy  in  1  result consumer accept.
REQ-015 SHALL have port rsp_res  out  W  packed result.
REQ-016 SHALL have port rsp_id  out  1  originating requester index.
REQ-017 SHALL have port busy  out  1  high while any operation in flight or FIFO non-empty.

Function
REQ-018 SHALL accept at most one request per cycle; handshake = req_vld[i] & req_rdy[i].
REQ-019 SHALL assert req_rdy[i] only for the arbitration winner and only when credit > 0; req_rdy SHALL NOT depend on the other requester's req_rdy.
REQ-020 SHALL arbitrate round-robin: after a grant to i, requester 1-i has priority next; a lone requester wins every cycle.
REQ-021 SHALL register the winner's operands: mul_vld=1, mul_a/mul_b = winner's a/b in cycle t+1 for a handshake in cycle t; mul_vld=0 otherwise.
REQ-022 SHALL track an internal MUL_LAT-deep valid/id shift pipe aligned with mul_res and SHALL capture mul_res with id into the FIFO when the tracked valid emerges.
REQ-023 SHALL give handshake-to-rsp_vld latency of MUL_LAT+2 cycles when FIFO empty and rsp_rdy=1 (5 at default).
REQ-024 SHALL keep a credit counter, reset to FIFO_DEPTH; -1 on request handshake, +1 on response handshake, unchanged when both occur in one cycle.
REQ-025 SHALL never overflow the FIFO: credit=0 forces req_rdy=0 regardless of requests.
REQ-026 SHALL present results in issue order; rsp_res/rsp_id SHALL hold stable while rsp_vld=1 and rsp_rdy=0.
REQ-027 SHALL allow simultaneous FIFO write and read when full or empty without loss or duplication.
REQ-028 SHALL pass operands/results bit-exact; no arithmetic is performed in this block.

Reset
REQ-029 SHALL on rst set req_rdy=0, mul_vld=0, mul_a=mul_b=0, rsp_vld=0, rsp_res=0, rsp_id=0, busy=0, credit=FIFO_DEPTH, priority to requester 0.
REQ-030 SHALL clear the tracked pipe on rst; results of operations in flight at reset SHALL be discarded even if mul_res later toggles.

Configuration
REQ-031 SHALL, with macro MUL_PIPE_ARB_FIXED_PRIO_EN defined, use fixed priority (requester 0 always wins when both valid); without it, round-robin per REQ-020.

Verification
REQ-032 SHALL cover: req0 only, a=0x3FC00000 (1.5), b=0x40000000 (2.0), model mul returns 0x40400000 -> rsp_vld 5 cycles later, rsp_res=0x40400000, rsp_id=0.
REQ-033 SHALL cover: both req_vld held high 6 cycles, rsp_rdy=1 -> grants alternate 0,1,0,1,0,1; with MUL_PIPE_ARB_FIXED_PRIO_EN all six grants to 0.
REQ-034 SHALL cover: rsp_rdy=0, req0 continuous -> exactly 4 accepts, req_rdy=0 thereafter, rsp_vld held with first result stable; rsp_rdy=1 one cycle -> one new accept.
REQ-035 SHALL cover: credit=1 with simultaneous accept and response handshake -> credit remains 1, no FIFO overflow, order preserved.
REQ-036 SHALL cover: rst asserted 2 cycles after an accept -> no rsp_vld for 10 cycles afterward, credit=4, busy=0.
